// File: rtl/screen_fill_engine.sv
// Raster pixel-sweep engine: on a stage enable it writes every framebuffer pixel
// once (flat fill or grid overlay) and returns a done flag to the display FSM.
module screen_fill_engine #(
    parameter int H_RES      = 160,
    parameter int V_RES      = 120,
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int GRID_PITCH = 20,
    parameter int COL_W      = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             grid_mode,
    input  logic [COL_W-1:0] bg_colour,
    input  logic [COL_W-1:0] line_colour,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             done
);

    localparam int P_W = $clog2(GRID_PITCH);
    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);
    localparam logic [P_W-1:0] P_LAST = P_W'(GRID_PITCH - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t           state, state_n;
    logic [X_W-1:0]   x_n, adv_x;
    logic [Y_W-1:0]   y_n, adv_y;
    logic [P_W-1:0]   px, px_n, adv_px;
    logic [P_W-1:0]   py, py_n, adv_py;
    logic [COL_W-1:0] colour_n;
    logic             plot_n, done_n;
    logic             gm_q, gm_n;
    logic [COL_W-1:0] bg_q, bg_n, line_q, line_n;
    logic             on_line;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            px     <= '0;
            py     <= '0;
            colour <= '0;
            plot   <= 1'b0;
            done   <= 1'b0;
            gm_q   <= 1'b0;
            bg_q   <= '0;
            line_q <= '0;
        end else begin
            state  <= state_n;
            x      <= x_n;
            y      <= y_n;
            px     <= px_n;
            py     <= py_n;
            colour <= colour_n;
            plot   <= plot_n;
            done   <= done_n;
            gm_q   <= gm_n;
            bg_q   <= bg_n;
            line_q <= line_n;
        end
    end

    // px/py track x mod GRID_PITCH and y mod GRID_PITCH without dividers
    always_comb begin
        adv_x  = x + 1'b1;
        adv_y  = y;
        adv_px = (px == P_LAST) ? '0 : px + 1'b1;
        adv_py = py;
        if (x == X_LAST) begin
            adv_x  = '0;
            adv_px = '0;
            adv_y  = y + 1'b1;
            adv_py = (py == P_LAST) ? '0 : py + 1'b1;
        end
        on_line = (adv_px == '0) || (adv_py == '0) || (adv_x == X_LAST) || (adv_y == Y_LAST);
    end

    always_comb begin
        state_n  = state;
        x_n      = '0;
        y_n      = '0;
        px_n     = '0;
        py_n     = '0;
        colour_n = '0;
        plot_n   = 1'b0;
        done_n   = 1'b0;
        gm_n     = gm_q;
        bg_n     = bg_q;
        line_n   = line_q;
        case (state)
            IDLE: begin
                if (en) begin
                    state_n  = SWEEP;
                    plot_n   = 1'b1;
                    gm_n     = grid_mode;
                    bg_n     = bg_colour;
                    line_n   = line_colour;
                    // pixel (0,0) always lies on a grid line
                    colour_n = grid_mode ? line_colour : bg_colour;
                end
            end
            SWEEP: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (x == X_LAST && y == Y_LAST) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    x_n      = adv_x;
                    y_n      = adv_y;
                    px_n     = adv_px;
                    py_n     = adv_py;
                    plot_n   = 1'b1;
                    colour_n = (gm_q && on_line) ? line_q : bg_q;
                end
            end
            DONE: begin
                if (!en) begin
                    state_n = IDLE;
                end else begin
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/screen_fill_engine.md
Name: screen_fill_engine

Overview:
- Pixel-sweep engine at the other end of the display-select handshake: it consumes one screen-stage enable (e.g. start-screen erase, grid draw) and returns the matching done flag to the display FSM.
- While enabled, it writes every pixel of an H_RES x V_RES framebuffer once, in raster order, one pixel per clock. The pixel is either a flat background fill or a background with grid lines.
- Sits between the display-select FSM and the VGA adapter write port (x, y, colour, plot).

Parameters:
- H_RES, 160, pixels per row; must be >= 2.
- V_RES, 120, rows per frame; must be >= 2.
- X_W, 8, width of x; 2^X_W >= H_RES.
- Y_W, 7, width of y; 2^Y_W >= V_RES.
- GRID_PITCH, 20, spacing of grid lines in pixels; must be >= 2.
- COL_W, 3, colour width.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- en  in  1  stage enable from the display FSM; level-sensitive.
- grid_mode  in  1  0 = flat fill; 1 = draw grid lines over the background.
- bg_colour  in  COL_W  background colour.
- line_colour  in  COL_W  grid line colour.
- x  out  X_W  pixel column.
- y  out  Y_W  pixel row.
- colour  out  COL_W  pixel colour; valid when plot=1.
- plot  out  1  framebuffer write strobe.
- done  out  1  sweep-complete flag to the display FSM.

Behaviour:
- Clock and reset: clk; resetn synchronous, active-low.
- Reset values: state=IDLE, x=0, y=0, plot=0, done=0, colour=0, latched grid_mode/bg/line=0. Reset overrides all other inputs, including mid-sweep.
- States: IDLE, SWEEP, DONE. All outputs registered.
- IDLE:
  - plot=0, done=0.
  - en=1 sampled -> next cycle SWEEP with x=0, y=0, plot=1.
  - grid_mode, bg_colour and line_colour are latched on that same edge.
- SWEEP:
  - plot=1 every cycle. Inputs changing mid-sweep are ignored; the latched values are used.
  - Per edge with en=1: if x<H_RES-1 then x<=x+1; else x<=0 and y<=y+1.
  - At (H_RES-1, V_RES-1) with en=1: next state DONE, plot=0, done=1, x=0, y=0.
  - plot is high for exactly H_RES*V_RES consecutive cycles, each (x,y) exactly once, row-major.
  - done rises in the cycle immediately after the last plot cycle.
- Abort: en=0 sampled in SWEEP -> next cycle IDLE, plot=0, done=0, x=0, y=0. done is never asserted for an aborted sweep. A later en=1 restarts from (0,0).
- DONE:
  - done=1, plot=0; held while en=1.
  - en=0 -> next cycle IDLE, done=0.
  - A new sweep requires en to be low for at least one cycle (IDLE), then high again.
- Colour function (registered alongside x,y, so colour matches the x,y presented with plot):
  - Latched grid_mode=0: colour = bg.
  - Latched grid_mode=1: colour = line when x mod GRID_PITCH==0, y mod GRID_PITCH==0, x==H_RES-1, or y==V_RES-1; otherwise bg.
  - Modulo is implemented with wrap-around pitch counters (reset to 0 at x wrap / frame start), not dividers.
- Widths: x and y never exceed H_RES-1 and V_RES-1; no counter overflow. Total sweep latency from en rise to done rise is H_RES*V_RES+1 cycles.
- Simultaneous events:
  - resetn=0 wins over everything.
  - en=0 on the final SWEEP pixel edge -> IDLE, done stays 0.

Test Plan:
- Flat fill (H_RES=8, V_RES=4, grid_mode=0, bg=3'b101): en rises at cycle 0 -> plot=1 cycles 1..32; x,y go (0,0),(1,0)...(7,0),(0,1)...(7,3); colour=5 throughout; done=1 from cycle 33; plot=0 from cycle 33.
- Grid (H_RES=8, V_RES=8, GRID_PITCH=4, bg=0, line=3'b111): pixels with x∈{0,4,7} or y∈{0,4,7} -> colour=7; e.g. (1,1) -> 0, (4,2) -> 7, (7,5) -> 7, (2,3) -> 0.
- Abort: en drops after 10 plot cycles -> next cycle plot=0, done=0, x=y=0; en re-raised -> sweep restarts at (0,0) and completes 32 pixels.
- Handshake: hold en=1 in DONE for 5 cycles -> done stays 1, no plot. Drop en -> done=0 next cycle. Raise en -> new full sweep.
- Input freeze: change bg_colour 5 -> 2 and grid_mode 0 -> 1 mid-sweep -> all pixels of the current sweep keep colour 5; the next sweep uses the new values.
- Reset mid-sweep: resetn=0 for 1 cycle at pixel 12 -> x=0, y=0, plot=0, done=0. With en still high, the sweep restarts from (0,0) the cycle after reset releases.
